// File: rtl/panda_pkg.sv
// panda_pkg: shared types and constants for the panda data-memory arbiter.
//   dmem_owner_e     - which requester owns a RAM beat (core or host)
//   dmem_arb_state_e - arbiter FSM states (round-robin, host lock)
package panda_pkg;

  typedef enum logic {
    DmemOwnerCore = 1'b0,
    DmemOwnerHost = 1'b1
  } dmem_owner_e;

  typedef enum logic {
    DmemArbRr   = 1'b0,
    DmemArbLock = 1'b1
  } dmem_arb_state_e;

  // Lock beat counter width; covers the legal MaxLockBeats range 1..255.
  localparam int unsigned DmemLockCntWidth = 8;

endpackage

// File: rtl/panda_arb_rr2.sv
// panda_arb_rr2: two-input round-robin grant.
//   i_clk, i_rst      - clock, asynchronous active-high reset
//   i_req_core/host   - requests
//   i_upd             - a grant was issued this cycle (updates last owner)
//   i_upd_host        - the issued grant went to the host
//   o_gnt_core/host   - round-robin grant (combinational)
// The last owner resets to host so the core wins the first tie.
module panda_arb_rr2
  import panda_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_core,
  input  logic i_req_host,
  input  logic i_upd,
  input  logic i_upd_host,
  output logic o_gnt_core,
  output logic o_gnt_host
);

  dmem_owner_e r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= DmemOwnerHost;
    end else if (i_upd) begin
      r_last <= i_upd_host ? DmemOwnerHost : DmemOwnerCore;
    end
  end

  // On a tie the side opposite the last owner wins.
  always_comb begin
    o_gnt_core = i_req_core & (~i_req_host | (r_last == DmemOwnerHost));
    o_gnt_host = i_req_host & (~i_req_core | (r_last == DmemOwnerCore));
  end

endmodule

// File: rtl/panda_dmem_arbiter.sv
// panda_dmem_arbiter: shares the single-port data RAM between the core
// load-store port and the host (loader/debug) port.
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   core_* / host_*     - requester ports (req, we, addr, wdata, gnt,
//                         rvalid, rdata); host_lock_i keeps ownership
//   mem_*               - RAM port; synchronous read, data valid one
//                         cycle after the access
// Round-robin arbitration with a host lock for bursts; the lock is broken
// after MaxLockBeats consecutive locked beats if the core is waiting.
module panda_dmem_arbiter
  import panda_pkg::*;
#(
  parameter int unsigned AddrWidth    = 5,
  parameter int unsigned MaxLockBeats = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 core_req_i,
  input  logic [3:0]           core_we_i,
  input  logic [AddrWidth-1:0] core_addr_i,
  input  logic [31:0]          core_wdata_i,
  output logic                 core_gnt_o,
  output logic                 core_rvalid_o,
  output logic [31:0]          core_rdata_o,
  input  logic                 host_req_i,
  input  logic                 host_lock_i,
  input  logic [3:0]           host_we_i,
  input  logic [AddrWidth-1:0] host_addr_i,
  input  logic [31:0]          host_wdata_i,
  output logic                 host_gnt_o,
  output logic                 host_rvalid_o,
  output logic [31:0]          host_rdata_o,
  output logic                 mem_ce_o,
  output logic [3:0]           mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);

  localparam logic [DmemLockCntWidth-1:0] LockMax = DmemLockCntWidth'(MaxLockBeats);

  dmem_arb_state_e             r_state;
  dmem_arb_state_e             w_state_nxt;
  logic [DmemLockCntWidth-1:0] r_lock_cnt;
  logic [DmemLockCntWidth-1:0] w_lock_cnt_nxt;
  logic                        r_rvalid;
  dmem_owner_e                 r_rd_owner;

  logic w_rr_gnt_core;
  logic w_rr_gnt_host;
  logic w_core_gnt;
  logic w_host_gnt;
  logic w_rd_grant;

  panda_arb_rr2 u_rr (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_req_core (core_req_i),
    .i_req_host (host_req_i),
    .i_upd      (w_core_gnt | w_host_gnt),
    .i_upd_host (w_host_gnt),
    .o_gnt_core (w_rr_gnt_core),
    .o_gnt_host (w_rr_gnt_host)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= DmemArbRr;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_comb begin
    w_core_gnt     = 1'b0;
    w_host_gnt     = 1'b0;
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      DmemArbRr: begin
        w_core_gnt = w_rr_gnt_core;
        w_host_gnt = w_rr_gnt_host;
        if (w_rr_gnt_host && host_lock_i) begin
          w_state_nxt    = DmemArbLock;
          w_lock_cnt_nxt = DmemLockCntWidth'(1);
        end
      end
      DmemArbLock: begin
        if ((r_lock_cnt == LockMax) && core_req_i) begin
          // Starvation cap: the waiting core takes this beat.
          w_core_gnt     = 1'b1;
          w_state_nxt    = DmemArbRr;
          w_lock_cnt_nxt = '0;
        end else if (!host_req_i) begin
          w_state_nxt    = DmemArbRr;
          w_lock_cnt_nxt = '0;
        end else begin
          w_host_gnt = 1'b1;
          if (!host_lock_i) begin
            w_state_nxt    = DmemArbRr;
            w_lock_cnt_nxt = '0;
          end else if (r_lock_cnt < LockMax) begin
            w_lock_cnt_nxt = r_lock_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt    = DmemArbRr;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_core_gnt) begin
      mem_we_o    = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (w_host_gnt) begin
      mem_we_o    = host_we_i;
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_wdata_i;
    end
  end

  assign mem_ce_o   = w_core_gnt | w_host_gnt;
  assign core_gnt_o = w_core_gnt;
  assign host_gnt_o = w_host_gnt;
  assign w_rd_grant = (w_core_gnt & (core_we_i == 4'b0000)) |
                      (w_host_gnt & (host_we_i == 4'b0000));

  // The read owner remembers who issued the outstanding read so the
  // shared RAM data can be flagged to the right side next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid   <= 1'b0;
      r_rd_owner <= DmemOwnerCore;
    end else begin
      r_rvalid <= w_rd_grant;
      if (w_rd_grant) begin
        r_rd_owner <= w_host_gnt ? DmemOwnerHost : DmemOwnerCore;
      end
    end
  end

  assign core_rvalid_o = r_rvalid & (r_rd_owner == DmemOwnerCore);
  assign host_rvalid_o = r_rvalid & (r_rd_owner == DmemOwnerHost);
  assign core_rdata_o  = mem_rdata_i;
  assign host_rdata_o  = mem_rdata_i;

endmodule

// File: doc/panda_dmem_arbiter.md
Name: panda_dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the core load-store port and a host port used for program/data loading and debug access.
- Arbitration is round-robin with a host lock for multi-beat bursts.
- A lock-beat limit bounds how long the core can be starved.
- Sits between the single-cycle datapath's data interface and the data RAM instance, which has synchronous read and no output register.

Parameters:
- AddrWidth, 5, word-address width (log2 of data memory depth).
- MaxLockBeats, 8, maximum consecutive locked host grants before a forced release; legal range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- core_req_i  in  1  core request; held stable until granted.
- core_we_i  in  4  core byte write enables; 0 means read.
- core_addr_i  in  AddrWidth  core word address.
- core_wdata_i  in  32  core write data.
- core_gnt_o  out  1  core request accepted this cycle.
- core_rvalid_o  out  1  core read data valid.
- core_rdata_o  out  32  core read data.
- host_req_i  in  1  host request; held stable until granted.
- host_lock_i  in  1  host requests to keep ownership after this beat.
- host_we_i  in  4  host byte write enables.
- host_addr_i  in  AddrWidth  host word address.
- host_wdata_i  in  32  host write data.
- host_gnt_o  out  1  host request accepted.
- host_rvalid_o  out  1  host read data valid.
- host_rdata_o  out  32  host read data.
- mem_ce_o  out  1  RAM chip enable.
- mem_we_o  out  4  RAM byte write enables.
- mem_addr_o  out  AddrWidth  RAM word address.
- mem_wdata_o  out  32  RAM write data.
- mem_rdata_i  in  32  RAM read data, valid the cycle after the access.

Behaviour:
- Grant is combinational in the request cycle. At most one of core_gnt_o and host_gnt_o is high.
- Granted side's we, addr and wdata drive the mem_* outputs. mem_ce_o = core_gnt_o | host_gnt_o.
- With no grant: mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- Read latency is 1. A granted read (we == 0) sets the granted side's rvalid high in the next cycle for exactly one cycle.
- Both rdata outputs carry mem_rdata_i. Only the rvalid of the registered owner is asserted.
- Granted writes produce no rvalid.
- States:
  - ARB: round-robin. When only one side requests, that side is granted. When both request, the side opposite last_grant wins.
  - LOCK: host owns the RAM. host_gnt_o = host_req_i. core_gnt_o = 0.
- Transitions:
  - ARB -> LOCK: host granted with host_lock_i = 1. lock_cnt is set to 1.
  - LOCK -> LOCK: host granted with host_lock_i = 1 and lock_cnt < MaxLockBeats. lock_cnt increments.
  - LOCK -> ARB on any of:
    - host granted with host_lock_i = 0;
    - host_req_i = 0 for one cycle (no grant issued that cycle);
    - lock_cnt == MaxLockBeats while core_req_i = 1, in which case the core is granted that cycle, the host is refused, and last_grant becomes core.
  - If lock_cnt == MaxLockBeats and core_req_i = 0, the host continues and lock_cnt saturates.
- last_grant updates on every grant.
- Reset values:
  - state = ARB.
  - last_grant = host, so the core wins the first tie.
  - lock_cnt = 0.
  - both rvalid = 0.
  - read-owner register = core.
- All grant and mem_* outputs are combinational from the registered state, so they are 0 during reset when no request is present.
- Reset mid-read drops the pending rvalid; no response is issued after reset deasserts.
- A request asserted in the same cycle as a pending rvalid is legal; back-to-back reads give one rvalid per cycle.

Decomposition:
- Add to panda_pkg:
  - dmem_owner_e {DmemOwnerCore, DmemOwnerHost};
  - dmem_arb_state_e {DmemArbRr, DmemArbLock}.
- One natural sub-module, panda_arb_rr2: a 2-input round-robin grant with last_grant register and update enable.
- FSM, lock counter and response routing remain in panda_dmem_arbiter.

Test Plan:
- Core-only read:
  - Stimulus: core_req = 1, we = 0, addr = 3, RAM word 3 = 0xDEADBEEF.
  - Response: core_gnt = 1, mem_addr = 3 same cycle; next cycle core_rvalid = 1 with rdata = 0xDEADBEEF, host_rvalid = 0.
- Tie after reset:
  - Stimulus: both request reads for 4 cycles.
  - Response: grants alternate core, host, core, host. Each rvalid follows its grant by one cycle.
- Host burst write with lock:
  - Stimulus: host writes addr 0..3 with lock = 1, 1, 1, 0 while the core requests continuously.
  - Response: 4 host grants, no core grant; core granted the cycle after the unlocked beat.
- Starvation cap:
  - Stimulus: MaxLockBeats = 2; host streams locked beats while the core requests.
  - Response: host granted 2 beats, then the core is granted in the third cycle; thereafter normal round-robin.
- Byte write:
  - Stimulus: core we = 4'b0010, wdata = 0x0000AB00, addr = 1.
  - Response: mem_we = 4'b0010, mem_ce = 1; a later read of addr 1 returns byte 1 = 0xAB with other bytes unchanged.
- Reset mid-read:
  - Stimulus: assert rst_i in the cycle after a granted core read.
  - Response: core_rvalid = 0 immediately and stays 0 after release; state is ARB; the first tie grants the core.
